// File: rtl/fwft_small_fifo_pkg.sv
// fwft_small_fifo_pkg: shared default geometry for the small FWFT FIFO
package fwft_small_fifo_pkg;
  localparam int DEF_WIDTH = 72;
  localparam int DEF_DEPTH_BITS = 3;
endpackage

// File: rtl/fwft_fifo_regfile.sv
// fwft_fifo_regfile: register array with one write port and an asynchronous read port
module fwft_fifo_regfile #(
  parameter int WIDTH = 8,
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fwft_small_fifo.sv
// fwft_small_fifo: first-word-fall-through FIFO on a register array, flags decoded from registered occupancy
module fwft_small_fifo
  import fwft_small_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_DEPTH_BITS = DEF_DEPTH_BITS,
  parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);
  localparam int DEPTH = 2**MAX_DEPTH_BITS;
  typedef logic [MAX_DEPTH_BITS-1:0] ptr_t;
  typedef logic [MAX_DEPTH_BITS:0] cnt_t;
  localparam cnt_t DEPTH_C = DEPTH[MAX_DEPTH_BITS:0];
  localparam cnt_t PF_C = PROG_FULL_THRESHOLD[MAX_DEPTH_BITS:0];
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data;
  logic rd_ok, wr_ok;
  assign empty = cnt_q == '0;
  assign full = cnt_q == DEPTH_C;
  assign nearly_full = cnt_q >= DEPTH_C - cnt_t'(1);
  assign prog_full = cnt_q >= PF_C;
  // A pop while full frees a slot, so the simultaneous push is accepted
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    cnt_d = cnt_q + cnt_t'(wr_ok) - cnt_t'(rd_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  fwft_fifo_regfile #(.WIDTH(WIDTH), .AW(MAX_DEPTH_BITS)) u_regfile (
    .clk(clk),
    .we(wr_ok),
    .waddr(wr_ptr_q),
    .wdata(din),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );
  // Empty shows zero so reset state is deterministic despite uninitialised storage
  assign dout = empty ? '0 : rd_data;
endmodule

// File: tb/tb_fwft_small_fifo.sv
// tb_fwft_small_fifo: directed scoreboard bench for the FWFT FIFO (WIDTH=8, depth 8)
module tb_fwft_small_fifo;
  logic clk = 1'b0;
  logic reset, wr_en, rd_en;
  logic [7:0] din, dout;
  logic full, nearly_full, prog_full, empty;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  fwft_small_fifo #(.WIDTH(8), .MAX_DEPTH_BITS(3), .PROG_FULL_THRESHOLD(7)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .nearly_full(nearly_full), .prog_full(prog_full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n = sb.size();
    chk({tag, ".empty"}, {7'd0, empty}, {7'd0, n == 0});
    chk({tag, ".full"}, {7'd0, full}, {7'd0, n == 8});
    chk({tag, ".nearly_full"}, {7'd0, nearly_full}, {7'd0, n >= 7});
    chk({tag, ".prog_full"}, {7'd0, prog_full}, {7'd0, n >= 7});
    if (n > 0) chk({tag, ".dout"}, dout, sb[0]);
  endtask

  // Check current outputs, then drive one cycle and advance the reference model
  task automatic step(input string tag, input logic w, input logic [7:0] d, input logic r);
    logic rd_acc, wr_acc;
    check_state(tag);
    wr_en = w;
    din = d;
    rd_en = r;
    rd_acc = r && sb.size() > 0;
    wr_acc = w && (sb.size() < 8 || rd_acc);
    if (rd_acc) void'(sb.pop_front());
    if (wr_acc) sb.push_back(d);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset.dout", dout, 8'h00);
    step("t1_idle", 0, 0, 0);
    step("t1_idle2", 0, 0, 0);
    step("t2_wr", 1, 8'hA5, 0);
    chk("t2_fwft", dout, 8'hA5);
    step("t2_hold", 0, 0, 0);
    step("t2_rd", 0, 0, 1);
    step("t2_after", 0, 0, 0);
    for (int i = 1; i <= 8; i++) step($sformatf("t3_wr%0d", i), 1, i[7:0], 0);
    step("t3_drop", 1, 8'hEE, 0);
    step("t3_full", 0, 0, 0);
    chk("t3_full_flag", {7'd0, full}, 8'h01);
    step("t4_wrrd", 1, 8'h09, 1);
    chk("t4_dout2", dout, 8'h02);
    chk("t4_still_full", {7'd0, full}, 8'h01);
    for (int i = 0; i < 8; i++) step($sformatf("t4_rd%0d", i), 0, 0, 1);
    chk("t4_empty", {7'd0, empty}, 8'h01);
    for (int i = 0; i < 20; i++) step($sformatf("t5_mix%0d", i), 1, 8'h20 + i[7:0], (i % 4) != 0);
    for (int i = 0; i < 10; i++) step($sformatf("t5_drain%0d", i), 0, 0, 1);
    step("t5_done", 0, 0, 0);
    for (int i = 0; i < 5; i++) step($sformatf("t6_wr%0d", i), 1, 8'h60 + i[7:0], 0);
    check_state("t6_pre");
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("t6_reset_empty", {7'd0, empty}, 8'h01);
    chk("t6_reset_dout", dout, 8'h00);
    step("t6_rd_empty", 0, 0, 1);
    step("t6_after", 0, 0, 0);
    step("t6_wr_after", 1, 8'h7E, 1);
    step("t6_final", 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
